// File: rtl/mult_acc_pkg.sv
// Shared types and constants for the product accumulator that sits behind
// the 4x4 array multiplier.
package mult_acc_pkg;

    localparam int PROD_W     = 8;
    localparam int MAX_PROD   = 225;
    localparam int TERM_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;

    // Counter value held while the final product of a sum is being accepted.
    function automatic logic [TERM_CNT_W-1:0] last_term_idx(input int n_terms);
        return TERM_CNT_W'(n_terms - 1);
    endfunction

endpackage

// File: rtl/mult_product_accumulator_if.sv
// Bus between the multiplier output stage, the accumulator and the pin mux.
// The accumulator's FSM state rides along as a debug signal.
interface mult_product_accumulator_if #(
    parameter int ACC_W = 10
);
    import mult_acc_pkg::*;

    logic [PROD_W-1:0]     p_in;
    logic                  p_valid;
    logic                  p_ready;
    logic [ACC_W-1:0]      acc_out;
    logic                  acc_valid;
    logic                  acc_ready;
    logic [TERM_CNT_W-1:0] term_cnt;
    logic                  overflow;
    acc_state_t            state;

    // Drives products and consumes results.
    modport master (
        output p_in, p_valid, acc_ready,
        input  p_ready, acc_out, acc_valid, term_cnt, overflow, state
    );

    // The accumulator itself.
    modport slave (
        input  p_in, p_valid, acc_ready,
        output p_ready, acc_out, acc_valid, term_cnt, overflow, state
    );

endinterface

// File: rtl/mult_product_accumulator_sat_adder.sv
// Unsigned accumulator adder; either clamps at all-ones or wraps on carry-out,
// and always reports the raw carry so overflow can be tracked.
module sat_adder #(
    parameter int ACC_W    = 10,
    parameter int SATURATE = 1
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [ACC_W-1:0] addend_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             carry_o
);

    logic [ACC_W:0] full_sum;

    assign full_sum = {1'b0, acc_i} + {1'b0, addend_i};
    assign carry_o  = full_sum[ACC_W];

    generate
        if (SATURATE != 0) begin : g_sat
            // A clamped accumulator plus any non-zero addend carries again,
            // so the value stays pinned at all-ones for the rest of the sum.
            assign sum_o = carry_o ? {ACC_W{1'b1}} : full_sum[ACC_W-1:0];
        end else begin : g_wrap
            assign sum_o = full_sum[ACC_W-1:0];
        end
    endgenerate

endmodule

// File: rtl/mult_product_accumulator.sv
// Sums N_TERMS multiplier products into one result and holds it on a
// valid/ready output until the consumer takes it.
module mult_product_accumulator
    import mult_acc_pkg::*;
#(
    parameter int N_TERMS  = 4,
    parameter int ACC_W    = 10,
    parameter int SATURATE = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    mult_product_accumulator_if.slave   bus
);

    localparam logic [TERM_CNT_W-1:0] LAST_IDX = last_term_idx(N_TERMS);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high. p_ready and acc_valid are decoded from registered state only,
    // so they never depend combinationally on p_valid or acc_ready.

    acc_state_t            state_q, state_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [TERM_CNT_W-1:0] cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;

    logic [ACC_W-1:0]      addend;
    logic [ACC_W-1:0]      sum;
    logic                  carry;
    logic                  accept;

    assign addend = ACC_W'(bus.p_in);
    assign accept = bus.p_valid && (state_q != DONE);

    sat_adder #(
        .ACC_W    (ACC_W),
        .SATURATE (SATURATE)
    ) u_sat_adder (
        .acc_i    (acc_q),
        .addend_i (addend),
        .sum_o    (sum),
        .carry_o  (carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        if (clear) begin
            // Drops any product offered this cycle and any pending result.
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc_d   = sum;
                        cnt_d   = cnt_q + 1'b1;
                        ovf_d   = ovf_q | carry;
                        state_d = (cnt_q == LAST_IDX) ? DONE : ACCUM;
                    end
                end
                DONE: begin
                    if (bus.acc_ready) begin
                        state_d = IDLE;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    assign bus.p_ready   = (state_q != DONE);
    assign bus.acc_valid = (state_q == DONE);
    assign bus.acc_out   = acc_q;
    assign bus.term_cnt  = cnt_q;
    assign bus.overflow  = ovf_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_mult_product_accumulator.sv
// Directed bench driving three accumulator variants (10-bit saturating,
// 8-bit saturating, 8-bit wrapping) in lockstep against a sum-level model.
module tb_mult_product_accumulator;
    import mult_acc_pkg::*;

    localparam int N_INST = 3;
    localparam int N_T    = 4;
    localparam int W_TAB   [N_INST] = '{10, 8, 8};
    localparam int SAT_TAB [N_INST] = '{1, 1, 0};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic [7:0] p_in = '0;
    logic       p_valid = 1'b0;
    logic       acc_ready = 1'b0;

    int  total = 0;
    int  bad = 0;
    bit  check_en = 1'b0;

    // Model: true (unbounded) sum, accepted count, result-held flag.
    int  m_sum  [N_INST];
    int  m_cnt  [N_INST];
    bit  m_done [N_INST];

    always #5 clk = ~clk;

    mult_product_accumulator_if #(.ACC_W(10)) bus0 ();
    mult_product_accumulator_if #(.ACC_W(8))  bus1 ();
    mult_product_accumulator_if #(.ACC_W(8))  bus2 ();

    assign bus0.p_in = p_in;  assign bus0.p_valid = p_valid;  assign bus0.acc_ready = acc_ready;
    assign bus1.p_in = p_in;  assign bus1.p_valid = p_valid;  assign bus1.acc_ready = acc_ready;
    assign bus2.p_in = p_in;  assign bus2.p_valid = p_valid;  assign bus2.acc_ready = acc_ready;

    mult_product_accumulator #(.N_TERMS(N_T), .ACC_W(10), .SATURATE(1)) dut0 (
        .clk(clk), .rst(rst), .clear(clear), .bus(bus0)
    );
    mult_product_accumulator #(.N_TERMS(N_T), .ACC_W(8), .SATURATE(1)) dut1 (
        .clk(clk), .rst(rst), .clear(clear), .bus(bus1)
    );
    mult_product_accumulator #(.N_TERMS(N_T), .ACC_W(8), .SATURATE(0)) dut2 (
        .clk(clk), .rst(rst), .clear(clear), .bus(bus2)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_acc(input int i);
        int mx;
        mx = (1 << W_TAB[i]) - 1;
        if (SAT_TAB[i] != 0) return (m_sum[i] > mx) ? mx : m_sum[i];
        return m_sum[i] % (mx + 1);
    endfunction

    function automatic int exp_ovf(input int i);
        return (m_sum[i] > (1 << W_TAB[i]) - 1) ? 1 : 0;
    endfunction

    function automatic int exp_state(input int i);
        if (m_done[i]) return int'(DONE);
        return (m_cnt[i] == 0) ? int'(IDLE) : int'(ACCUM);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < N_INST; i++) begin
            if (rst || clear || (m_done[i] && acc_ready)) begin
                m_sum[i]  = 0;
                m_cnt[i]  = 0;
                m_done[i] = 1'b0;
            end else if (!m_done[i] && p_valid) begin
                m_sum[i] = m_sum[i] + int'(p_in);
                m_cnt[i] = m_cnt[i] + 1;
                if (m_cnt[i] == N_T) m_done[i] = 1'b1;
            end
        end
    end

    task automatic cmp_inst(input int i, input int acc, input int vld, input int rdy,
                            input int cnt, input int ovf, input int st);
        check($sformatf("u%0d_acc_out", i),   acc, exp_acc(i));
        check($sformatf("u%0d_acc_valid", i), vld, m_done[i] ? 1 : 0);
        check($sformatf("u%0d_p_ready", i),   rdy, m_done[i] ? 0 : 1);
        check($sformatf("u%0d_term_cnt", i),  cnt, m_cnt[i] % 16);
        check($sformatf("u%0d_overflow", i),  ovf, exp_ovf(i));
        check($sformatf("u%0d_state", i),     st,  exp_state(i));
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            cmp_inst(0, int'(bus0.acc_out), int'(bus0.acc_valid), int'(bus0.p_ready),
                     int'(bus0.term_cnt), int'(bus0.overflow), int'(bus0.state));
            cmp_inst(1, int'(bus1.acc_out), int'(bus1.acc_valid), int'(bus1.p_ready),
                     int'(bus1.term_cnt), int'(bus1.overflow), int'(bus1.state));
            cmp_inst(2, int'(bus2.acc_out), int'(bus2.acc_valid), int'(bus2.p_ready),
                     int'(bus2.term_cnt), int'(bus2.overflow), int'(bus2.state));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int v);
        p_valid = 1'b1;
        p_in    = 8'(v);
        step();
        p_valid = 1'b0;
    endtask

    task automatic release_result();
        acc_ready = 1'b1;
        step();
        acc_ready = 1'b0;
    endtask

    initial begin
        int prods [4];

        // Reset held two cycles.
        step();
        check_en = 1'b1;
        step();
        rst = 1'b0;
        check("rst_acc_out",  int'(bus0.acc_out), 0);
        check("rst_p_ready",  int'(bus0.p_ready), 1);
        check("rst_state",    int'(bus0.state), int'(IDLE));

        // Four maximal products back-to-back.
        p_valid = 1'b1;
        p_in    = 8'(MAX_PROD);
        for (int k = 0; k < 4; k++) begin
            check("t1_p_ready", int'(bus0.p_ready), 1);
            step();
        end
        p_valid = 1'b0;
        check("t1_model_acc", exp_acc(0), 900);
        check("t1_acc_out",   int'(bus0.acc_out), 900);
        check("t1_acc_valid", int'(bus0.acc_valid), 1);
        check("t1_term_cnt",  int'(bus0.term_cnt), 4);
        check("t1_overflow",  int'(bus0.overflow), 0);
        check("t1_p_ready",   int'(bus0.p_ready), 0);
        check("t1_u1_acc",    int'(bus1.acc_out), 255);
        check("t1_u2_acc",    int'(bus2.acc_out), 132);

        // Result held while the consumer stalls.
        for (int k = 0; k < 5; k++) begin
            step();
            check("t2_hold_acc", int'(bus0.acc_out), 900);
            check("t2_hold_vld", int'(bus0.acc_valid), 1);
        end
        release_result();
        check("t2_acc_valid", int'(bus0.acc_valid), 0);
        check("t2_acc_out",   int'(bus0.acc_out), 0);
        check("t2_p_ready",   int'(bus0.p_ready), 1);

        // Gapped input stream.
        prods = '{6, 0, 15, 100};
        for (int k = 0; k < 4; k++) begin
            step();
            check("t3_idle_cnt", int'(bus0.term_cnt), k);
            feed(prods[k]);
            check("t3_term_cnt", int'(bus0.term_cnt), k + 1);
        end
        check("t3_model_acc", exp_acc(0), 121);
        check("t3_acc_out",   int'(bus0.acc_out), 121);
        check("t3_acc_valid", int'(bus0.acc_valid), 1);
        release_result();

        // Overflow behaviour of the narrow variants.
        prods = '{200, 100, 10, 1};
        for (int k = 0; k < 4; k++) feed(prods[k]);
        check("t4_model_sat", exp_acc(1), 255);
        check("t4_model_wrap", exp_acc(2), 55);
        check("t4_sat_acc",  int'(bus1.acc_out), 255);
        check("t4_sat_ovf",  int'(bus1.overflow), 1);
        check("t4_wrap_acc", int'(bus2.acc_out), 55);
        check("t4_wrap_ovf", int'(bus2.overflow), 1);
        check("t4_wide_acc", int'(bus0.acc_out), 311);
        check("t4_wide_ovf", int'(bus0.overflow), 0);
        release_result();

        // Clear mid-sum, coinciding with an offered product.
        feed(50);
        feed(60);
        check("t5_mid_acc", int'(bus0.acc_out), 110);
        clear   = 1'b1;
        p_valid = 1'b1;
        p_in    = 8'd70;
        step();
        clear   = 1'b0;
        p_valid = 1'b0;
        check("t5_clr_acc",   int'(bus0.acc_out), 0);
        check("t5_clr_cnt",   int'(bus0.term_cnt), 0);
        check("t5_clr_state", int'(bus0.state), int'(IDLE));

        // Same with reset.
        feed(50);
        feed(60);
        rst     = 1'b1;
        p_valid = 1'b1;
        p_in    = 8'd70;
        step();
        rst     = 1'b0;
        p_valid = 1'b0;
        check("t5_rst_acc",   int'(bus0.acc_out), 0);
        check("t5_rst_cnt",   int'(bus0.term_cnt), 0);
        check("t5_rst_ovf",   int'(bus0.overflow), 0);
        check("t5_rst_vld",   int'(bus0.acc_valid), 0);
        check("t5_rst_ready", int'(bus0.p_ready), 1);

        // Clear wins over a result handshake, then a fresh sum.
        for (int k = 0; k < 4; k++) feed(7);
        check("t6_done_acc", int'(bus0.acc_out), 28);
        clear     = 1'b1;
        acc_ready = 1'b1;
        step();
        clear     = 1'b0;
        acc_ready = 1'b0;
        check("t6_clr_vld", int'(bus0.acc_valid), 0);
        check("t6_clr_acc", int'(bus0.acc_out), 0);
        for (int k = 0; k < 4; k++) feed(1);
        check("t6_model_acc", exp_acc(0), 4);
        check("t6_acc_out",   int'(bus0.acc_out), 4);
        check("t6_acc_valid", int'(bus0.acc_valid), 1);
        release_result();
        step();

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
